// File: rtl/uart_tx_slave.sv
// Memory-mapped 8N1 UART transmitter (TXDATA / STATUS / BAUDDIV) with a 1-cycle bus response.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry transmit FIFO; otherwise a single holding register is used.
module uart_tx_slave #(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ss,
   input  logic        bstart,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [1:0]  tsize,
   input  logic        twrite,
   output logic [31:0] rdata,
   output logic        bdone,
   output logic        berror,
   output logic        tx
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   typedef enum logic [1:0] {REG_TXDATA, REG_STATUS, REG_BAUDDIV, REG_NONE} reg_t;

   state_t        state, state_n;
   reg_t          offset;
   logic [15:0]   baud_div;
   logic [15:0]   bit_cnt, cnt_n;
   logic [2:0]    bit_idx, idx_n;
   logic [7:0]    shreg, sh_n;
   logic [7:0]    head;
   logic [CW-1:0] count;
   logic [7:0]    count_ext;
   logic          full, empty, push, pop;
   logic          accept, req_err, div_we;
   logic [31:0]   resp_data, status_word;
   logic          unused_bits;

   assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16]};
   assign accept      = ss && bstart;
   assign offset      = reg_t'(addr[3:2]);
   assign count_ext   = 8'(count);
   assign status_word = {16'h0000, count_ext, 5'b00000, empty, full, state != IDLE};

   // A failing transfer must have no side effect, so push/div_we are only raised on the success path.
   always_comb begin
      req_err   = 1'b0;
      push      = 1'b0;
      div_we    = 1'b0;
      resp_data = '0;
      if (accept) begin
         case (offset)
            REG_TXDATA: begin
               if (twrite) begin
                  if (full) req_err = 1'b1;
                  else      push    = 1'b1;
               end
            end
            REG_STATUS: begin
               if (!twrite) resp_data = status_word;
            end
            REG_BAUDDIV: begin
               if (tsize != 2'd2) req_err   = 1'b1;
               else if (twrite)   div_we    = 1'b1;
               else               resp_data = {16'h0000, baud_div};
            end
            default: req_err = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bdone    <= 1'b0;
         berror   <= 1'b0;
         rdata    <= '0;
         baud_div <= DEFAULT_DIV;
      end else begin
         bdone  <= accept;
         berror <= req_err;
         rdata  <= resp_data;
         if (div_we) baud_div <= wdata[15:0];
      end
   end

`ifdef UART_TX_FIFO_EN
   localparam int unsigned   PW         = CW - 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
`else
   logic [7:0] hold_data;
   logic       hold_valid;

   assign full  = hold_valid;
   assign empty = !hold_valid;
   assign head  = hold_data;
   assign count = {{(CW-1){1'b0}}, hold_valid};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_data  <= '0;
         hold_valid <= 1'b0;
      end else if (push) begin
         hold_data  <= wdata[7:0];
         hold_valid <= 1'b1;
      end else if (pop) begin
         hold_valid <= 1'b0;
      end
   end
`endif

   // Every state/bit entry reloads the timer from baud_div, so each bit lasts baud_div+1 clocks.
   always_comb begin
      state_n = state;
      cnt_n   = bit_cnt;
      idx_n   = bit_idx;
      sh_n    = shreg;
      pop     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               sh_n    = head;
               cnt_n   = baud_div;
               state_n = START;
            end
         end
         START: begin
            if (bit_cnt == '0) begin
               cnt_n   = baud_div;
               idx_n   = '0;
               state_n = DATA;
            end else begin
               cnt_n = bit_cnt - 16'd1;
            end
         end
         DATA: begin
            if (bit_cnt == '0) begin
               cnt_n = baud_div;
               sh_n  = {1'b0, shreg[7:1]};
               if (bit_idx == 3'd7) state_n = STOP;
               else                 idx_n   = bit_idx + 3'd1;
            end else begin
               cnt_n = bit_cnt - 16'd1;
            end
         end
         STOP: begin
            if (bit_cnt == '0) state_n = IDLE;
            else               cnt_n   = bit_cnt - 16'd1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_n;
         bit_cnt <= cnt_n;
         bit_idx <= idx_n;
         shreg   <= sh_n;
      end
   end

   // Decoded straight from the state register so an asynchronous reset forces the line high at once.
   always_comb begin
      tx = 1'b1;
      unique case (state)
         START:   tx = 1'b0;
         DATA:    tx = shreg[0];
         default: tx = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_uart_tx_slave.sv
// Directed self-checking bench for uart_tx_slave; follows UART_TX_FIFO_EN to pick the FIFO or holding-register scenario.
`timescale 1ns/1ps
module tb_uart_tx_slave;
   logic        clk = 1'b0, rst_n = 1'b0, ss = 1'b0, bstart = 1'b0, twrite = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [1:0]  tsize = '0;
   logic [31:0] rdata;
   logic        bdone, berror, tx;
   int unsigned cyc = 0;
   int          tests = 0, fails = 0;

   uart_tx_slave #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd433)) dut (
      .clk(clk), .rst_n(rst_n), .ss(ss), .bstart(bstart), .addr(addr), .wdata(wdata),
      .tsize(tsize), .twrite(twrite), .rdata(rdata), .bdone(bdone), .berror(berror), .tx(tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       output logic [31:0] rd, output logic be, output logic bd, output int unsigned t);
      @(negedge clk);
      t = cyc; ss = 1'b1; bstart = 1'b1; twrite = w; addr = a; wdata = d; tsize = sz;
      @(negedge clk);
      ss = 1'b0; bstart = 1'b0; twrite = 1'b0;
      rd = rdata; be = berror; bd = bdone;
   endtask

   task automatic wait_until(input int unsigned target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic be, bd; int unsigned t;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if ({tx, bdone, berror} !== 3'b100 || rdata !== 32'h0) begin
         fails++; $display("FAIL reset_outputs: got tx/bdone/berror=%b rdata=%h, expected 100 / 00000000", {tx, bdone, berror}, rdata);
      end
      rst_n = 1'b1;
      xfer(1'b0, 32'h1000_0004, 32'h0, 2'd2, rd, be, bd, t);
      tests++;
      if (bd !== 1'b1 || be !== 1'b0 || rd !== 32'h0000_0004) begin
         fails++; $display("FAIL reset_status: got bdone=%b berror=%b rdata=%h, expected 1 0 00000004", bd, be, rd);
      end
      xfer(1'b0, 32'h1000_0008, 32'h0, 2'd2, rd, be, bd, t);
      tests++;
      if (bd !== 1'b1 || be !== 1'b0 || rd !== 32'd433) begin
         fails++; $display("FAIL reset_bauddiv: got bdone=%b berror=%b rdata=%0d, expected 1 0 433", bd, be, rd);
      end
      tests++;
      if (tx !== 1'b1) begin
         fails++; $display("FAIL reset_tx_idle: got %b, expected 1", tx);
      end
   endtask

   task automatic test_single_byte();
      logic [31:0] rd; logic be, bd; int unsigned t;
      logic [9:0]  f;
      f = {1'b1, 8'hA5, 1'b0};
      xfer(1'b1, 32'h1000_0008, 32'd3, 2'd2, rd, be, bd, t);
      tests++;
      if (bd !== 1'b1 || be !== 1'b0) begin
         fails++; $display("FAIL single_div_write: got bdone=%b berror=%b, expected 1 0", bd, be);
      end
      xfer(1'b1, 32'h1000_0000, 32'hFFFF_FFA5, 2'd0, rd, be, bd, t);
      tests++;
      if (bd !== 1'b1 || be !== 1'b0 || tx !== 1'b1) begin
         fails++; $display("FAIL single_push: got bdone=%b berror=%b tx=%b, expected 1 0 1", bd, be, tx);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         tests++;
         if (tx !== f[i/4]) begin
            fails++; $display("FAIL single_frame clk %0d after start: got tx=%b, expected %b", i, tx, f[i/4]);
         end
      end
   endtask

`ifdef UART_TX_FIFO_EN
   task automatic test_fill_overflow(output int unsigned c);
      logic [31:0] rd; logic be, bd; int unsigned t;
      c = 0;
      xfer(1'b1, 32'h1000_0008, 32'd100, 2'd2, rd, be, bd, t);
      for (int i = 0; i <= 11; i++) begin
         @(negedge clk);
         if (i > 0) begin
            tests++;
            if (bdone !== 1'b1 || berror !== (i == 10)) begin
               fails++; $display("FAIL fill_resp %0d: got bdone=%b berror=%b, expected 1 %b", i - 1, bdone, berror, (i == 10));
            end
         end
         if (i == 11) begin
            tests++;
            if (rdata !== 32'h0000_0803) begin
               fails++; $display("FAIL fill_status: got %h, expected 00000803", rdata);
            end
         end
         if (i == 0) c = cyc;
         if (i < 10) begin
            ss = 1'b1; bstart = 1'b1; twrite = 1'b1; addr = 32'h1000_0000; wdata = 32'h30 + i; tsize = 2'd0;
         end else if (i == 10) begin
            twrite = 1'b0; addr = 32'h1000_0004; tsize = 2'd2;
         end else begin
            ss = 1'b0; bstart = 1'b0;
         end
      end
   endtask

   task automatic test_drain(input int unsigned c);
      logic [31:0] rd; logic be, bd; int unsigned t, st;
      logic [9:0]  f;
      for (int k = 1; k <= 8; k++) begin
         st = c + 2 + 1011 * k;
         f  = {1'b1, 8'(8'h30 + k), 1'b0};
         wait_until(st - 1);
         tests++;
         if (tx !== 1'b1) begin
            fails++; $display("FAIL drain_gap frame %0d: got tx=%b one clk before start, expected 1", k, tx);
         end
         @(negedge clk);
         tests++;
         if (tx !== 1'b0) begin
            fails++; $display("FAIL drain_start frame %0d: got tx=%b, expected 0", k, tx);
         end
         for (int b = 1; b <= 9; b++) begin
            wait_until(st + 50 + 101 * b);
            tests++;
            if (tx !== f[b]) begin
               fails++; $display("FAIL drain_bit frame %0d bit %0d: got %b, expected %b", k, b, tx, f[b]);
            end
         end
      end
      wait_until(c + 2 + 1011 * 9 + 2);
      xfer(1'b0, 32'h1000_0004, 32'h0, 2'd2, rd, be, bd, t);
      tests++;
      if (bd !== 1'b1 || rd !== 32'h0000_0004) begin
         fails++; $display("FAIL drain_status: got bdone=%b rdata=%h, expected 1 00000004", bd, rd);
      end
   endtask
`else
   task automatic test_holding();
      logic [31:0] rd; logic be, bd; int unsigned t, c, st;
      logic [4:0]  exp_err;
      logic [9:0]  f;
      exp_err = 5'b01010;
      c = 0;
      for (int i = 0; i <= 5; i++) begin
         @(negedge clk);
         if (i > 0) begin
            tests++;
            if (bdone !== 1'b1 || berror !== exp_err[i-1]) begin
               fails++; $display("FAIL hold_resp %0d: got bdone=%b berror=%b, expected 1 %b", i - 1, bdone, berror, exp_err[i-1]);
            end
         end
         if (i == 5) begin
            tests++;
            if (rdata !== 32'h0000_0103) begin
               fails++; $display("FAIL hold_status: got %h, expected 00000103", rdata);
            end
         end
         if (i == 0) c = cyc;
         if (i < 4) begin
            ss = 1'b1; bstart = 1'b1; twrite = 1'b1; addr = 32'h1000_0000; wdata = 32'h61 + i; tsize = 2'd2;
         end else if (i == 4) begin
            twrite = 1'b0; addr = 32'h1000_0004;
         end else begin
            ss = 1'b0; bstart = 1'b0;
         end
      end
      for (int k = 0; k < 2; k++) begin
         st = c + 2 + 41 * k;
         f  = (k == 0) ? {1'b1, 8'h61, 1'b0} : {1'b1, 8'h63, 1'b0};
         if (k == 1) begin
            wait_until(st - 1);
            tests++;
            if (tx !== 1'b1) begin
               fails++; $display("FAIL hold_gap: got tx=%b one clk before start, expected 1", tx);
            end
         end
         for (int b = 0; b <= 9; b++) begin
            wait_until(st + 4 * b + 2);
            tests++;
            if (tx !== f[b]) begin
               fails++; $display("FAIL hold_frame %0d bit %0d: got %b, expected %b", k, b, tx, f[b]);
            end
         end
      end
      wait_until(c + 2 + 41 * 2 + 2);
      xfer(1'b0, 32'h1000_0004, 32'h0, 2'd2, rd, be, bd, t);
      tests++;
      if (rd !== 32'h0000_0004) begin
         fails++; $display("FAIL hold_final_status: got %h, expected 00000004", rd);
      end
   endtask
`endif

   task automatic test_errors();
      logic [31:0] rd; logic be, bd; int unsigned t;
      xfer(1'b1, 32'h1000_0008, 32'd7, 2'd2, rd, be, bd, t);
      tests++;
      if (be !== 1'b0) begin fails++; $display("FAIL err_div_ok: got berror=%b, expected 0", be); end
      xfer(1'b0, 32'h1000_000C, 32'h0, 2'd2, rd, be, bd, t);
      tests++;
      if (bd !== 1'b1 || be !== 1'b1 || rd !== 32'h0) begin
         fails++; $display("FAIL err_unmapped: got bdone=%b berror=%b rdata=%h, expected 1 1 00000000", bd, be, rd);
      end
      xfer(1'b1, 32'h1000_0008, 32'd5, 2'd0, rd, be, bd, t);
      tests++;
      if (be !== 1'b1) begin fails++; $display("FAIL err_div_byte_write: got berror=%b, expected 1", be); end
      xfer(1'b0, 32'h1000_0008, 32'h0, 2'd1, rd, be, bd, t);
      tests++;
      if (be !== 1'b1 || rd !== 32'h0) begin
         fails++; $display("FAIL err_div_half_read: got berror=%b rdata=%h, expected 1 00000000", be, rd);
      end
      xfer(1'b1, 32'h1000_0004, 32'hFFFF_FFFF, 2'd2, rd, be, bd, t);
      tests++;
      if (be !== 1'b0) begin fails++; $display("FAIL err_status_write: got berror=%b, expected 0", be); end
      xfer(1'b0, 32'h1000_0000, 32'h0, 2'd2, rd, be, bd, t);
      tests++;
      if (be !== 1'b0 || rd !== 32'h0) begin
         fails++; $display("FAIL err_txdata_read: got berror=%b rdata=%h, expected 0 00000000", be, rd);
      end
      xfer(1'b0, 32'h1000_0008, 32'h0, 2'd2, rd, be, bd, t);
      tests++;
      if (be !== 1'b0 || rd !== 32'd7) begin
         fails++; $display("FAIL err_div_unchanged: got berror=%b rdata=%0d, expected 0 7", be, rd);
      end
      @(negedge clk);
      bstart = 1'b1; twrite = 1'b1; addr = 32'h1000_0000; wdata = 32'h55; tsize = 2'd0;
      @(negedge clk);
      bstart = 1'b0; twrite = 1'b0;
      tests++;
      if (bdone !== 1'b0) begin fails++; $display("FAIL err_no_ss: got bdone=%b, expected 0", bdone); end
      xfer(1'b0, 32'h1000_0004, 32'h0, 2'd2, rd, be, bd, t);
      tests++;
      if (rd !== 32'h0000_0004) begin fails++; $display("FAIL err_no_ss_status: got %h, expected 00000004", rd); end
   endtask

   task automatic test_mid_frame_reset();
      logic [31:0] rd; logic be, bd; int unsigned t, c;
      logic        all_high;
      xfer(1'b1, 32'h1000_0008, 32'd3, 2'd2, rd, be, bd, t);
      xfer(1'b1, 32'h1000_0000, 32'h00, 2'd0, rd, be, bd, c);
      xfer(1'b1, 32'h1000_0000, 32'hFF, 2'd0, rd, be, bd, t);
      tests++;
      if (be !== 1'b0) begin fails++; $display("FAIL mfr_second_push: got berror=%b, expected 0", be); end
      wait_until(c + 8);
      tests++;
      if (tx !== 1'b0) begin fails++; $display("FAIL mfr_in_data: got tx=%b, expected 0", tx); end
      rst_n = 1'b0;
      #1;
      tests++;
      if (tx !== 1'b1) begin fails++; $display("FAIL mfr_async_tx: got tx=%b, expected 1", tx); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      xfer(1'b0, 32'h1000_0004, 32'h0, 2'd2, rd, be, bd, t);
      tests++;
      if (bd !== 1'b1 || rd !== 32'h0000_0004) begin
         fails++; $display("FAIL mfr_status: got bdone=%b rdata=%h, expected 1 00000004", bd, rd);
      end
      xfer(1'b0, 32'h1000_0008, 32'h0, 2'd2, rd, be, bd, t);
      tests++;
      if (rd !== 32'd433) begin fails++; $display("FAIL mfr_bauddiv: got %0d, expected 433", rd); end
      all_high = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) all_high = 1'b0;
      end
      tests++;
      if (all_high !== 1'b1) begin fails++; $display("FAIL mfr_line_idle: got a low tx sample, expected constant 1"); end
   endtask

   initial begin
      int unsigned fill_c;
      fill_c = 0;
      test_reset();
      test_single_byte();
`ifdef UART_TX_FIFO_EN
      test_fill_overflow(fill_c);
      test_drain(fill_c);
`else
      test_holding();
`endif
      test_errors();
      test_mid_frame_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
